// File: rtl/size_explore_pkg.sv
// Shared types and sizing helpers for the size-exploration measurement harness.
package size_explore_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int BYTE_W = 8;

    function automatic int res_bytes(input int res_w);
        return res_w / BYTE_W;
    endfunction

    function automatic int lat_bytes(input int lat_w);
        return lat_w / BYTE_W;
    endfunction

    // Width of the byte-select index; never narrower than one bit.
    function automatic int rd_sel_w(input int res_w, input int lat_w);
        int w;
        w = $clog2(res_bytes(res_w) + lat_bytes(lat_w));
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/size_explore_harness_bank.sv
// Serial-in operand bank: NUM_OPS independent shift registers, MSB first.
module serial_operand_bank #(
    parameter int NUM_OPS = 3,
    parameter int OP_W    = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    shift_en,
    input  logic [NUM_OPS-1:0]      ser_in,
    output logic [NUM_OPS*OP_W-1:0] ops
);

    logic [NUM_OPS-1:0][OP_W-1:0] ops_q, ops_d;

    always_comb begin
        ops_d = ops_q;
        if (shift_en) begin
            for (int i = 0; i < NUM_OPS; i++) begin
                ops_d[i] = {ops_q[i][OP_W-2:0], ser_in[i]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) ops_q <= '0;
        else       ops_q <= ops_d;
    end

    assign ops = ops_q;

endmodule

// File: rtl/size_explore_harness.sv
// Measurement harness: loads operands serially, launches the MUT, times it and
// returns result/latency bytewise. Define HARNESS_TIMEOUT_EN to enable run abort.
module size_explore_harness
    import size_explore_pkg::*;
#(
    parameter int NUM_OPS = 3,
    parameter int OP_W    = 32,
    parameter int RES_W   = 32,
    parameter int LAT_W   = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_OPS-1:0]                 ser_in,
    input  logic                               shift_en,
    input  logic                               start,
    input  logic [rd_sel_w(RES_W, LAT_W)-1:0]  rd_sel,
    output logic [7:0]                         rd_data,
    output logic [NUM_OPS*OP_W-1:0]            mut_operands,
    output logic                               mut_start,
    input  logic                               mut_done,
    input  logic [RES_W-1:0]                   mut_result,
    output logic                               busy,
    output logic                               res_valid,
    output logic                               timed_out
);

    localparam int RSW    = rd_sel_w(RES_W, LAT_W);
    localparam int NBYTES = res_bytes(RES_W) + lat_bytes(LAT_W);
    localparam logic [LAT_W-1:0] LAT_MAX = '1;

    if (NUM_OPS < 1 || NUM_OPS > 8 || OP_W < 2 || (RES_W % 8) != 0 || (LAT_W % 8) != 0 ||
        TIMEOUT < 1 || (64'(TIMEOUT) >> LAT_W) != 0) begin : g_bad_params
        $error("size_explore_harness: illegal parameter combination");
    end

    state_e             state_q, state_d;
    logic [LAT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [RES_W-1:0]   res_q, res_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic               mut_start_q, mut_start_d;
    logic               busy_q, busy_d;
    logic               res_valid_q, res_valid_d;
    logic [7:0]         rd_data_q, rd_data_d;
    logic [RES_W+LAT_W-1:0] rd_vec;
    logic               launch, done_ok, tmo_hit, shift_go;

    assign launch   = start && (state_q != RUN);
    assign shift_go = shift_en && !start && (state_q != RUN);
    // The launch cycle itself never accepts a completion.
    assign done_ok  = (state_q == RUN) && mut_done && !mut_start_q;
    assign cnt_inc  = (cnt_q == LAT_MAX) ? cnt_q : cnt_q + LAT_W'(1);
    assign rd_vec   = {lat_q, res_q};

    serial_operand_bank #(
        .NUM_OPS (NUM_OPS),
        .OP_W    (OP_W)
    ) u_bank (
        .clk      (clk),
        .reset    (reset),
        .shift_en (shift_go),
        .ser_in   (ser_in),
        .ops      (mut_operands)
    );

`ifdef HARNESS_TIMEOUT_EN
    localparam logic [LAT_W-1:0] TIMEOUT_V = LAT_W'(TIMEOUT);
    logic timed_out_q, timed_out_d;

    // A completion in the same cycle as the limit takes priority.
    assign tmo_hit = (state_q == RUN) && !done_ok && (cnt_inc == TIMEOUT_V);

    always_comb begin
        timed_out_d = timed_out_q;
        if (launch)       timed_out_d = 1'b0;
        else if (tmo_hit) timed_out_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) timed_out_q <= 1'b0;
        else       timed_out_q <= timed_out_d;
    end

    assign timed_out = timed_out_q;
`else
    assign tmo_hit   = 1'b0;
    assign timed_out = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        res_d       = res_q;
        lat_d       = lat_q;
        mut_start_d = 1'b0;
        busy_d      = busy_q;
        res_valid_d = res_valid_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (launch) begin
                    state_d     = RUN;
                    mut_start_d = 1'b1;
                    cnt_d       = '0;
                    busy_d      = 1'b1;
                    res_valid_d = 1'b0;
                end
            end
            RUN: begin
                cnt_d = cnt_inc;
                if (done_ok || tmo_hit) begin
                    res_d       = done_ok ? mut_result : '0;
                    lat_d       = cnt_inc;
                    state_d     = DONE;
                    busy_d      = 1'b0;
                    res_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        rd_data_d = 8'h00;
        for (int k = 0; k < NBYTES; k++) begin
            if (rd_sel == RSW'(k)) rd_data_d = rd_vec[8*k +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            res_q       <= '0;
            lat_q       <= '0;
            mut_start_q <= 1'b0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            rd_data_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            res_q       <= res_d;
            lat_q       <= lat_d;
            mut_start_q <= mut_start_d;
            busy_q      <= busy_d;
            res_valid_q <= res_valid_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign mut_start = mut_start_q;
    assign busy      = busy_q;
    assign res_valid = res_valid_q;
    assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_size_explore_harness.sv
// Scoreboard bench: stimulus task runs a transaction-level model and queues the
// expected outputs per edge; a negedge monitor pops and compares them.
module tb_size_explore_harness;

    localparam int NUM_OPS = 3;
    localparam int OP_W    = 32;
    localparam int RES_W   = 32;
    localparam int LAT_W   = 16;
    localparam int TO      = 20;
    localparam int NB      = (RES_W + LAT_W) / 8;
    localparam int SW      = 3;
    localparam logic [7:0] RD_EXP [8] = '{8'h0D, 8'hF0, 8'hFE, 8'hCA, 8'h05, 8'h00, 8'h00, 8'h00};

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    shift_en = 1'b0;
    logic                    start = 1'b0;
    logic                    mut_done = 1'b0;
    logic [NUM_OPS-1:0]      ser_in = '0;
    logic [SW-1:0]           rd_sel = '0;
    logic [RES_W-1:0]        mut_result = '0;
    logic [7:0]              rd_data;
    logic [NUM_OPS*OP_W-1:0] mut_operands;
    logic                    mut_start, busy, res_valid, timed_out;

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;

    size_explore_harness #(
        .NUM_OPS (NUM_OPS), .OP_W (OP_W), .RES_W (RES_W), .LAT_W (LAT_W), .TIMEOUT (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ser_in       (ser_in),
        .shift_en     (shift_en),
        .start        (start),
        .rd_sel       (rd_sel),
        .rd_data      (rd_data),
        .mut_operands (mut_operands),
        .mut_start    (mut_start),
        .mut_done     (mut_done),
        .mut_result   (mut_result),
        .busy         (busy),
        .res_valid    (res_valid),
        .timed_out    (timed_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                    cyc;
        logic [7:0]            rd;
        logic                  busy, vld, to, ms;
        logic [NUM_OPS*OP_W-1:0] ops;
    } item_t;
    item_t exp_q[$];

    // Transaction-level model: operands, captured result/latency, launch edge.
    logic [OP_W-1:0]  m_ops [NUM_OPS];
    logic [RES_W-1:0] m_res;
    logic [LAT_W-1:0] m_lat;
    bit               m_run, m_vld, m_to;
    int               m_n;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int sel);
        logic [RES_W+LAT_W-1:0] v;
        v = {m_lat, m_res};
        if (sel >= NB) return 8'h00;
        return 8'(v >> (8 * sel));
    endfunction

    function automatic logic [NUM_OPS*OP_W-1:0] pack_ops();
        logic [NUM_OPS*OP_W-1:0] p;
        p = '0;
        for (int i = NUM_OPS - 1; i >= 0; i--) p = (p << OP_W) | (NUM_OPS*OP_W)'(m_ops[i]);
        return p;
    endfunction

    task automatic step(input logic rst, input logic sh, input logic st, input logic dn,
                        input logic [NUM_OPS-1:0] si, input logic [RES_W-1:0] res,
                        input logic [SW-1:0] sel);
        item_t it;
        int    e;
        longint d;
        reset = rst; shift_en = sh; start = st; mut_done = dn;
        ser_in = si; mut_result = res; rd_sel = sel;
        e = cyc + 1;
        it.cyc = e;
        it.ms  = 1'b0;
        if (rst) begin
            for (int i = 0; i < NUM_OPS; i++) m_ops[i] = '0;
            m_res = '0; m_lat = '0; m_run = 0; m_vld = 0; m_to = 0;
            it.rd = 8'h00;
        end else begin
            it.rd = exp_byte(int'(sel));
            if (!m_run) begin
                if (st) begin
                    m_run = 1; m_n = e; m_vld = 0; m_to = 0; it.ms = 1'b1;
                end else if (sh) begin
                    for (int i = 0; i < NUM_OPS; i++) m_ops[i] = (m_ops[i] << 1) | OP_W'(si[i]);
                end
            end else begin
                d = longint'(e - m_n);
                if (dn && e != m_n + 1) begin
                    m_res = res;
                    m_lat = (d >= (longint'(1) << LAT_W)) ? '1 : LAT_W'(d);
                    m_run = 0; m_vld = 1;
                end
`ifdef HARNESS_TIMEOUT_EN
                else if (d == TO) begin
                    m_res = '0; m_lat = LAT_W'(TO); m_to = 1; m_run = 0; m_vld = 1;
                end
`endif
            end
        end
        it.busy = m_run; it.vld = m_vld; it.to = m_to; it.ops = pack_ops();
        exp_q.push_back(it);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0, RES_W'($urandom), '0);
    endtask

    always @(negedge clk) begin
        item_t it;
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            it = exp_q.pop_front();
            chk("rd_data",      rd_data,      it.rd);
            chk("busy",         busy,         it.busy);
            chk("res_valid",    res_valid,    it.vld);
            chk("timed_out",    timed_out,    it.to);
            chk("mut_start",    mut_start,    it.ms);
            chk("mut_operands", mut_operands, it.ops);
        end
    end

    initial begin
        logic [OP_W-1:0] c0, c1, c2, r;
        c0 = 32'hDEADBEEF; c1 = 32'h01234567; c2 = 32'hFFFFFFFF;

        step(1, 0, 0, 0, '0, '0, '0);
        step(1, 0, 0, 0, '0, '0, '0);
        chk("reset_rd", rd_data, 8'h00);
        chk("reset_busy", busy, 1'b0);

        // completion strobe while idle must be ignored
        step(0, 0, 0, 1, '0, 32'h55AA55AA, '0);
        step(0, 0, 0, 1, '0, 32'h55AA55AA, '0);
        chk("done_in_idle", res_valid, 1'b0);

        for (int i = 0; i < OP_W; i++)
            step(0, 1, 0, 0, {c2[OP_W-1-i], c1[OP_W-1-i], c0[OP_W-1-i]}, '0, '0);
        chk("load", mut_operands, {c2, c1, c0});

        step(0, 0, 1, 0, '0, '0, '0);
        chk("launch_pulse", mut_start, 1'b1);
        idle(4);
        step(0, 0, 0, 1, '0, 32'hCAFEF00D, '0);
        chk("run_valid", res_valid, 1'b1);
        for (int k = 0; k < 8; k++) begin
            step(0, 0, 0, 0, '0, '0, SW'(k));
            chk($sformatf("readout%0d", k), rd_data, RD_EXP[k]);
        end

        // start with shift_en: no shift; start in RUN: no second pulse
        step(0, 1, 1, 0, '1, '0, '0);
        chk("start_over_shift", mut_operands, {c2, c1, c0});
        step(0, 0, 1, 1, '0, 32'h11111111, '0);
        chk("no_second_pulse", mut_start, 1'b0);
        step(0, 0, 1, 0, '0, '0, '0);
        step(0, 0, 0, 1, '0, 32'h0BADF00D, '0);
        step(0, 0, 0, 0, '0, '0, SW'(4));
        chk("lat3", rd_data, 8'h03);

        // back-to-back launch from DONE keeps operands
        step(0, 0, 1, 0, '0, '0, '0);
        chk("b2b_valid_drop", res_valid, 1'b0);
        idle(6);
        r = $urandom;
        step(0, 0, 0, 1, '0, r, '0);
        step(0, 0, 0, 0, '0, '0, SW'(4));
        chk("b2b_lat", rd_data, 8'h07);
        step(0, 0, 0, 0, '0, '0, SW'(0));
        chk("b2b_res0", rd_data, r[7:0]);
        chk("b2b_ops", mut_operands, {c2, c1, c0});

        // reset three cycles into a run
        step(0, 0, 1, 0, '0, '0, SW'(0));
        idle(2);
        step(1, 0, 0, 0, '0, '0, SW'(0));
        chk("rst_busy", busy, 1'b0);
        chk("rst_ms", mut_start, 1'b0);
        chk("rst_rd", rd_data, 8'h00);
        chk("rst_ops", mut_operands, '0);

`ifdef HARNESS_TIMEOUT_EN
        step(0, 0, 1, 0, '0, '0, '0);
        idle(24);
        chk("to_flag", timed_out, 1'b1);
        step(0, 0, 0, 0, '0, '0, SW'(4));
        chk("to_lat_lo", rd_data, 8'h14);
        step(0, 0, 0, 0, '0, '0, SW'(5));
        chk("to_lat_hi", rd_data, 8'h00);
        step(0, 0, 0, 0, '0, '0, SW'(0));
        chk("to_res", rd_data, 8'h00);
        step(0, 0, 1, 0, '0, '0, '0);
        idle(19);
        step(0, 0, 0, 1, '0, 32'h12345678, '0);
        chk("to_done_wins", timed_out, 1'b0);
        step(0, 0, 0, 0, '0, '0, SW'(0));
        chk("to_done_res", rd_data, 8'h78);
`endif

        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) < 1, $urandom_range(0, 99) < 40,
                 $urandom_range(0, 99) < 6, $urandom_range(0, 99) < 15,
                 NUM_OPS'($urandom), RES_W'($urandom), SW'($urandom_range(0, 7)));
        end

        idle(2);
        @(negedge clk);
        #1;
        chk("drain", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/size_explore_harness.md
# size_explore_harness

Parametrised measurement harness for area/latency exploration of a module under test (MUT) on a pin-limited tile. It loads NUM_OPS serial operand streams into shift registers, launches the MUT with a one-cycle start pulse, and waits for its done strobe. It then captures the result and the measured latency, and returns both byte-by-byte through an 8-bit registered read port. It sits between the top-level pin wrapper and the MUT instance.

## Interface
- NUM_OPS, 3: number of operand channels (1..8)
- OP_W, 32: operand width in bits (≥2)
- RES_W, 32: MUT result width, multiple of 8
- LAT_W, 16: latency counter width, multiple of 8
- TIMEOUT, 1000: RUN cycles before abort (only with timeout feature); must be < 2^LAT_W
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- ser_in  in  NUM_OPS  serial operand bits, one per channel
- shift_en  in  1  shift ser_in into operand registers this cycle
- start  in  1  request a MUT run
- rd_sel  in  $clog2((RES_W+LAT_W)/8)  byte index for readout
- rd_data  out  8  registered readout byte
- mut_operands  out  NUM_OPS*OP_W  operand bus; channel i at [OP_W*i +: OP_W]
- mut_start  out  1  one-cycle launch pulse
- mut_done  in  1  MUT completion strobe
- mut_result  in  RES_W  MUT result, valid with mut_done
- busy  out  1  high in RUN
- res_valid  out  1  high in DONE
- timed_out  out  1  last run aborted (timeout build only, else tied 0)

## Operation
- States: IDLE, RUN, DONE. Reset: IDLE, all operands 0, result 0, latency 0, mut_start/busy/res_valid/timed_out/rd_data 0.
- Shift (IDLE or DONE, shift_en=1, start=0): each channel i does op_i <= {op_i[OP_W-2:0], ser_in[i]}. MSB enters first. shift_en is ignored in RUN.
- start in IDLE or DONE: go to RUN; mut_start=1 for the next cycle only; latency counter cleared to 0; res_valid cleared; timed_out cleared. If start and shift_en are both high, start wins and no shift occurs. start is ignored in RUN.
- RUN: latency counter increments every cycle, saturating at 2^LAT_W−1. The cycle with mut_start high counts as 1.
- mut_done=1 in RUN: capture mut_result and the counter value, then go to DONE. mut_done is ignored in IDLE and DONE, and also in the cycle mut_start is asserted. Operands are held stable throughout RUN.
- Readout byte map: index k < RES_W/8 → result[8k +: 8]; next LAT_W/8 indices → latency bytes, low byte first. Indices past the end return 0.
- reset mid-RUN: abort immediately with no mut_start and no capture; all state returns to reset values.

## Timing
- Shift: operand visible on mut_operands the cycle after the shift_en edge. A full load takes OP_W cycles.
- start sampled at edge N → busy and mut_start high from N+1. mut_start drops at N+2.
- mut_done sampled at edge M → res_valid high and captured values readable from M+1.
- Recorded latency = M − N. If mut_done is held high from launch, the earliest capture is at M = N+2, giving latency 2.
- rd_data is registered: it reflects the rd_sel sampled at the previous edge, so readout has 1-cycle latency and runs in any state.

## Configuration
- HARNESS_TIMEOUT_EN defined: when the latency counter reaches TIMEOUT in RUN, go to DONE with result forced to 0, latency=TIMEOUT, timed_out=1. If mut_done arrives in that same cycle, mut_done wins and timed_out stays 0.
- Undefined: no timeout logic. RUN waits indefinitely and the counter saturates. timed_out is tied to 0.

## Structure
- Shared package size_explore_pkg holds:
  - the state enum (IDLE/RUN/DONE)
  - byte-count constants derived from RES_W/LAT_W
  - the readout index-width function.
- Sub-module serial_operand_bank: NUM_OPS×OP_W shift-register bank with shift enable and synchronous reset. Instantiated once.
- FSM, latency counter, capture registers and readout mux stay in the top.

## Test plan
- Load, defaults: shift 32 cycles with ch0 = 0xDEADBEEF, ch1 = 0x01234567, ch2 = 0xFFFFFFFF (MSB first) → mut_operands = {0xFFFFFFFF, 0x01234567, 0xDEADBEEF}.
- Run: start, MUT returns mut_done with result 0xCAFEF00D 5 cycles after start → rd_sel 0..3 read 0x0D, 0xF0, 0xFE, 0xCA; rd_sel 4..5 read 0x05, 0x00; rd_sel 7 reads 0x00.
- Priority and ignore rules:
  - start together with shift_en → no shift, single mut_start pulse.
  - start during RUN → no second pulse.
  - mut_done in IDLE → res_valid stays 0.
- Reset mid-RUN 3 cycles after start → next cycle busy=0, mut_start=0, rd_data=0, operands=0.
- HARNESS_TIMEOUT_EN with TIMEOUT=20 and no mut_done → DONE with timed_out=1, latency bytes 0x14, 0x00, result 0. Repeat with mut_done at count 20 → timed_out=0 and the MUT result is captured.
- Back-to-back: second start from DONE → res_valid drops at N+1, new latency measured correctly, operands retained without reload.
